// File: rtl/t06_edge_detect_multi_if.sv
// rtl/t06_edge_detect_multi_if.sv - input/output bundle for the multi-channel edge conditioner
interface t06_edge_detect_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   d;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   clr;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   edg;
  logic [CHANNELS-1:0]   pending;
  logic                  irq;

  modport master (
    output d, mode, clr,
    input  level, edg, pending, irq
  );

  modport slave (
    input  d, mode, clr,
    output level, edg, pending, irq
  );
endinterface

// File: rtl/t06_edge_detect_multi.sv
// rtl/t06_edge_detect_multi.sv - per-channel synchronizer, debounce filter and mode-qualified edge detector
module t06_edge_detect_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input logic                    clk,
  input logic                    rst,
  t06_edge_detect_multi_if.slave bus
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] syn;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] level_next;
  logic [CHANNELS-1:0] edg;
  logic [CHANNELS-1:0] edg_next;
  logic [CHANNELS-1:0] pending;
  logic [CNT_W-1:0]    cnt      [CHANNELS];
  logic [CNT_W-1:0]    cnt_next [CHANNELS];

  assign syn = sync_q[SYNC_STAGES-1];

  // Counter restarts whenever syn agrees with level, so only an unbroken run of DB_CYCLES commits
  always_comb begin
    level_next = level;
    edg_next   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_next[i] = '0;
      if (syn[i] != level[i]) begin
        if (cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          level_next[i] = syn[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
      edg_next[i] = (level_next[i] & ~level[i] & bus.mode[2*i]) |
                    (~level_next[i] & level[i] & bus.mode[2*i+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
      level   <= '0;
      edg     <= '0;
      pending <= '0;
    end else begin
      sync_q[0] <= bus.d;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= cnt_next[i];
      end
      level   <= level_next;
      edg     <= edg_next;
      // A new edge beats a same-cycle clear so no event is dropped
      pending <= (pending & ~bus.clr) | edg_next;
    end
  end

  assign bus.level   = level;
  assign bus.edg     = edg;
  assign bus.pending = pending;
  assign bus.irq     = |pending;
endmodule

// File: tb/tb_t06_edge_detect_multi.sv
// tb/tb_t06_edge_detect_multi.sv - directed self-checking bench for t06_edge_detect_multi
module tb_t06_edge_detect_multi;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  t06_edge_detect_multi_if #(.CHANNELS(4)) bus ();

  t06_edge_detect_multi #(
    .CHANNELS   (4),
    .SYNC_STAGES(2),
    .DB_CYCLES  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.d    = 4'b0000;
    bus.mode = 8'hFB;
    bus.clr  = 4'b0000;

    // T1: reset state, then first rise on ch0
    step(3);
    rst = 1'b0;
    chk("rst_level", {28'd0, bus.level}, 32'h0);
    chk("rst_edg", {28'd0, bus.edg}, 32'h0);
    chk("rst_pending", {28'd0, bus.pending}, 32'h0);
    chk("rst_irq", {31'd0, bus.irq}, 32'h0);
    bus.d = 4'b0001;
    step(5);
    chk("t1_level_e5", {28'd0, bus.level}, 32'h0);
    step(1);
    chk("t1_level_e6", {28'd0, bus.level}, 32'h1);
    chk("t1_edg_e6", {28'd0, bus.edg}, 32'h1);
    chk("t1_pending_e6", {28'd0, bus.pending}, 32'h1);
    chk("t1_irq_e6", {31'd0, bus.irq}, 32'h1);
    step(1);
    chk("t1_edg_e7", {28'd0, bus.edg}, 32'h0);
    bus.clr = 4'b0001;
    step(1);
    bus.clr = 4'b0000;
    chk("t1_clr", {28'd0, bus.pending}, 32'h0);
    chk("t1_clr_irq", {31'd0, bus.irq}, 32'h0);

    // T2: ch1 fall-only
    bus.d = 4'b0011;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk("t2_rise_level", {31'd0, bus.level[1]}, {31'd0, i >= 6});
      chk("t2_rise_edg", {31'd0, bus.edg[1]}, 32'h0);
    end
    chk("t2_rise_pending", {31'd0, bus.pending[1]}, 32'h0);
    bus.d = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk("t2_fall_level", {31'd0, bus.level[1]}, {31'd0, i < 6});
      chk("t2_fall_edg", {31'd0, bus.edg[1]}, {31'd0, i == 6});
    end
    chk("t2_fall_pending", {28'd0, bus.pending}, 32'h2);
    bus.clr = 4'b0010;
    step(1);
    bus.clr = 4'b0000;

    // T3: 3-cycle glitch is rejected, 4-cycle pulse is accepted
    bus.d = 4'b0101;
    step(3);
    bus.d = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk("t3_glitch_level", {31'd0, bus.level[2]}, 32'h0);
      chk("t3_glitch_edg", {31'd0, bus.edg[2]}, 32'h0);
    end
    chk("t3_glitch_pending", {28'd0, bus.pending}, 32'h0);
    bus.d = 4'b0101;
    step(4);
    bus.d = 4'b0001;
    step(1);
    chk("t3_pulse_level_e5", {31'd0, bus.level[2]}, 32'h0);
    step(1);
    chk("t3_pulse_level_e6", {31'd0, bus.level[2]}, 32'h1);
    chk("t3_pulse_edg_e6", {31'd0, bus.edg[2]}, 32'h1);
    chk("t3_pulse_pending", {28'd0, bus.pending}, 32'h4);
    step(3);
    chk("t3_level_e9", {31'd0, bus.level[2]}, 32'h1);
    step(1);
    chk("t3_level_e10", {31'd0, bus.level[2]}, 32'h0);
    chk("t3_fall_edg", {31'd0, bus.edg[2]}, 32'h1);
    bus.clr = 4'b0100;
    step(1);
    bus.clr = 4'b0000;
    chk("t3_clr", {28'd0, bus.pending}, 32'h0);

    // T4: clear coinciding with the edge loses nothing
    bus.d = 4'b1001;
    step(5);
    bus.clr = 4'b1000;
    step(1);
    bus.clr = 4'b0000;
    chk("t4_edg", {28'd0, bus.edg}, 32'h8);
    chk("t4_set_wins", {28'd0, bus.pending}, 32'h8);
    bus.clr = 4'b1000;
    step(1);
    bus.clr = 4'b0000;
    chk("t4_clr_alone", {28'd0, bus.pending}, 32'h0);
    chk("t4_irq", {31'd0, bus.irq}, 32'h0);

    // T5: all channels both-edge, toggled together
    bus.mode = 8'hFF;
    bus.d    = 4'b0000;
    step(10);
    bus.clr = 4'b1111;
    step(1);
    bus.clr = 4'b0000;
    chk("t5_settle_level", {28'd0, bus.level}, 32'h0);
    chk("t5_settle_pending", {28'd0, bus.pending}, 32'h0);
    for (int j = 0; j < 4; j++) begin
      bus.d = (j % 2 == 0) ? 4'hF : 4'h0;
      for (int i = 1; i <= 8; i++) begin
        step(1);
        chk("t5_edg", {28'd0, bus.edg}, (i == 6) ? 32'hF : 32'h0);
      end
      chk("t5_level", {28'd0, bus.level}, (j % 2 == 0) ? 32'hF : 32'h0);
      chk("t5_pending", {28'd0, bus.pending}, 32'hF);
    end
    bus.d = 4'hF;
    step(4);
    rst = 1'b1;
    step(1);
    rst   = 1'b0;
    bus.d = 4'h0;
    chk("t5_rst_level", {28'd0, bus.level}, 32'h0);
    chk("t5_rst_edg", {28'd0, bus.edg}, 32'h0);
    chk("t5_rst_pending", {28'd0, bus.pending}, 32'h0);
    chk("t5_rst_irq", {31'd0, bus.irq}, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("t5_post_rst_edg", {28'd0, bus.edg}, 32'h0);
      chk("t5_post_rst_level", {28'd0, bus.level}, 32'h0);
    end

    // T6: mode off on ch0, level still tracks
    bus.mode = 8'hFC;
    bus.d    = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("t6_rise_level", {31'd0, bus.level[0]}, {31'd0, i >= 6});
      chk("t6_rise_edg", {31'd0, bus.edg[0]}, 32'h0);
      chk("t6_rise_pending", {31'd0, bus.pending[0]}, 32'h0);
    end
    bus.d = 4'b0000;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("t6_fall_level", {31'd0, bus.level[0]}, {31'd0, i < 6});
      chk("t6_fall_edg", {31'd0, bus.edg[0]}, 32'h0);
      chk("t6_fall_pending", {31'd0, bus.pending[0]}, 32'h0);
    end
    chk("t6_irq", {31'd0, bus.irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
